nios2_onchip_mem_arbiter: RTL and testbench
===========================================

// Module: nios2_onchip_mem_arbiter
// PURPOSE
//   Two-requester round-robin arbiter for the single-port on-chip RAM (32-bit, 16000 words, 1-cycle read).
//   Sits between two Avalon-MM masters (m0, m1) and the RAM's address/byteenable/chipselect/write/writedata/readdata pins.
//   Grants at most one access per cycle, stalls the loser with waitrequest, and returns read data with readdatavalid.
//   Also blocks out-of-range accesses.
// PARAMETERS
//   DATA_W     32      data width in bits; BE_W = DATA_W/8
//   ADDR_W     14      word-address width
//   DEPTH      16000   implemented words; word addresses >= DEPTH are out of range (OOR)
//   OOR_RDATA  32'h0   data returned for an OOR read
// PORTS
//   clk                 in   1        single clock; all logic rises on posedge clk
//   reset_n             in   1        asynchronous assert, active-low reset
//   mK_address          in   ADDR_W   requester K (K = 0,1) word address
//   mK_byteenable       in   BE_W     requester K byte lanes for writes
//   mK_read             in   1        requester K read request
//   mK_write            in   1        requester K write request
//   mK_writedata        in   DATA_W   requester K write data
//   mK_waitrequest      out  1        requester K stall; request must hold stable while high
//   mK_readdata         out  DATA_W   requester K read data; valid only with readdatavalid
//   mK_readdatavalid    out  1        requester K one-cycle read-data strobe
//   mem_address         out  ADDR_W   to RAM address
//   mem_byteenable      out  BE_W     to RAM byteenable
//   mem_chipselect      out  1        to RAM chipselect
//   mem_write           out  1        to RAM write (RAM write enable = chipselect & write)
//   mem_writedata       out  DATA_W   to RAM writedata
//   mem_readdata        in   DATA_W   from RAM; data for the address presented one cycle earlier
// BEHAVIOUR
//   Request
//     - req_K = mK_read | mK_write.
//     - read & write both high: treated as a write; no read data is returned.
//   Grant (combinational)
//     - Single requester: granted immediately.
//     - Both requesting: the port named by prio_ptr wins.
//     - mK_waitrequest = req_K & ~gnt_K (0 when idle).
//   Priority pointer (register)
//     - On every grant, prio_ptr becomes the loser's index, or the other index if only one port requested.
//     - No grant: prio_ptr holds.
//     - Effect: with both ports requesting continuously, grants alternate strictly and no requester waits more than 1 cycle.
//   Memory side
//     - mem_* are combinational muxes of the granted port.
//     - mem_chipselect = any grant & ~OOR.
//     - mem_write = granted write & ~OOR.
//     - mem_byteenable is forced to all-ones on reads.
//     - With no grant, address/writedata/byteenable carry port 0 values and chipselect is 0.
//   Read return (registered tag pipe, latency 1)
//     - A granted read in cycle N sets tag {valid, port, oor} for cycle N+1.
//     - In N+1: mK_readdatavalid = tag.valid & (tag.port == K).
//     - mK_readdata = tag.oor ? OOR_RDATA : mem_readdata. Both ports see the same data; only the owner gets the strobe.
//     - Back-to-back reads, including alternating ports, return one result per cycle in grant order.
//   Writes
//     - A granted write completes in its grant cycle; there is no response.
//     - A write to an OOR address is dropped silently and still consumes a grant.
//   Read/write interleave
//     - A write granted in cycle N+1 after a read granted in cycle N does not corrupt the cycle-N read data.
//     - The RAM is read-during-write don't-care, but the addresses differ in time, so this holds.
//   Address arithmetic
//     - OOR = (address >= DEPTH), an unsigned compare on ADDR_W bits.
//     - No wrap: address 16383 is OOR, not aliased.
//   Reset (reset_n low, asynchronous)
//     - prio_ptr = 0, tag.valid = 0, so mK_readdatavalid = 0 immediately.
//     - Reset asserted mid-read kills the pending strobe.
//     - First arbitration after release favours m0.
// TESTING
//   T1 m0 read @0x0010 alone (RAM holds 0xCAFEF00D): m0_waitrequest=0, m0_readdatavalid=1 next cycle, m0_readdata=0xCAFEF00D; m1 strobe stays 0.
//   T2 both read continuously for 8 cycles after reset: grants m0,m1,m0,...; each waitrequest high exactly every other cycle; strobes alternate starting with m0.
//   T3 m1 write 0x11223344 @0x0100, be=4'b0101, then m0 read @0x0100 (prior 0xFFFFFFFF): m0_readdata=0xFF22FF44.
//   T4 m0 write @16000 then read @16000 and @16383: mem_chipselect=0 throughout; both reads return OOR_RDATA with readdatavalid=1; @15999 accesses normally.
//   T5 m0 read granted, reset_n pulsed low before the next edge: no m0_readdatavalid; after release, simultaneous requests grant m0 first.
//   T6 m0 read+write both high @0x0020, data 0xA5A5A5A5: treated as write, no strobe; a following read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/nios2_onchip_mem_arbiter_if.sv
// Avalon-MM requester port bundle for the on-chip RAM arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface nios2_onchip_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable,
    output read, write, writedata,
    input  waitrequest,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable,
    input  read, write, writedata,
    output waitrequest,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios2_onchip_mem_arbiter.sv
// Two-port round-robin arbiter for the single-port on-chip RAM.
// Out-of-range accesses never reach the RAM; OOR reads return a constant.
module nios2_onchip_mem_arbiter #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 14,
  parameter int              DEPTH     = 16000,
  parameter logic [DATA_W-1:0] OOR_RDATA = '0,
  localparam int             BE_W      = DATA_W / 8
) (
  input  logic               clk,
  input  logic               reset_n,
  nios2_onchip_mem_arbiter_if.slave m0,
  nios2_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BE_W-1:0]    mem_byteenable,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  input  logic [DATA_W-1:0]  mem_readdata
);

  typedef struct packed {
    logic valid;
    logic port;
    logic oor;
  } tag_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic any_gnt;
  logic sel_wr;
  logic sel_oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rdata;

  logic prio_q;
  logic prio_d;
  tag_t tag_q;
  tag_t tag_d;

  // Grant: lone requester wins, a tie goes to the pointer.
  always_comb begin
    req0 = m0.read | m0.write;
    req1 = m1.read | m1.write;
    gnt0 = req0 & (~req1 | ~prio_q);
    gnt1 = req1 & (~req0 | prio_q);
    any_gnt = gnt0 | gnt1;
  end

  assign m0.waitrequest = req0 & ~gnt0;
  assign m1.waitrequest = req1 & ~gnt1;

  // Steer the granted port; idle cycles show port 0.
  always_comb begin
    sel_addr  = gnt1 ? m1.address    : m0.address;
    sel_be    = gnt1 ? m1.byteenable : m0.byteenable;
    sel_wdata = gnt1 ? m1.writedata  : m0.writedata;
    sel_wr    = gnt1 ? m1.write      : m0.write;
    sel_oor   = {1'b0, sel_addr} >= DEPTH_W;
  end

  // RAM pins; reads use every byte lane.
  always_comb begin
    mem_address    = sel_addr;
    mem_writedata  = sel_wdata;
    mem_chipselect = any_gnt & ~sel_oor;
    mem_write      = any_gnt & sel_wr & ~sel_oor;
    mem_byteenable = (any_gnt & ~sel_wr) ? {BE_W{1'b1}} : sel_be;
  end

  // Pointer moves to the other port after each grant.
  always_comb begin
    prio_d = prio_q;
    unique case (1'b1)
      gnt0:    prio_d = 1'b1;
      gnt1:    prio_d = 1'b0;
      default: prio_d = prio_q;
    endcase
  end

  // Tag for the read whose data arrives next cycle.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = any_gnt & ~sel_wr;
    tag_d.port  = gnt1;
    tag_d.oor   = sel_oor;
  end

  // Pointer and read-tag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      prio_q <= prio_d;
      tag_q  <= tag_d;
    end
  end

  assign rdata = tag_q.oor ? OOR_RDATA : mem_readdata;

  assign m0.readdata      = rdata;
  assign m1.readdata      = rdata;
  assign m0.readdatavalid = tag_q.valid & ~tag_q.port;
  assign m1.readdatavalid = tag_q.valid &  tag_q.port;

endmodule

// File: tb/tb_nios2_onchip_mem_arbiter.sv
// Bench for nios2_onchip_mem_arbiter: directed scenarios plus
// random traffic scored against a transaction-level memory model.
module tb_nios2_onchip_mem_arbiter;

  typedef struct packed {
    logic        r;
    logic        w;
    logic [13:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } req_t;

  logic        clk;
  logic        reset_n;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  nios2_onchip_mem_arbiter_if #(.DATA_W(32), .ADDR_W(14)) m0_if ();
  nios2_onchip_mem_arbiter_if #(.DATA_W(32), .ADDR_W(14)) m1_if ();

  nios2_onchip_mem_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = n[8*b +: 8];
    return m;
  endfunction

  // Environment RAM: 16000 words, 1-cycle registered read, backdoor preload.
  logic [31:0] ram [0:15999];
  logic        pl_en;
  logic [13:0] pl_a;
  logic [31:0] pl_d;
  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (mem_chipselect && mem_address < 14'd16000) begin
      if (mem_write)
        ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else
        mem_readdata <= ram[mem_address];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  int          last_gnt;
  int          pend_port;
  logic [31:0] pend_rd;

  int checks = 0;
  int errors = 0;

  logic obs_rv0, obs_rv1, obs_w0, obs_w1, obs_cs, obs_mw;
  logic [31:0] obs_rd0, obs_rd1;
  logic [3:0]  obs_be;
  logic exp_rv0, exp_rv1, exp_w0, exp_w1, exp_cs, exp_mw;
  logic [31:0] exp_rd;

  function automatic req_t f_idle();
    return '{r: 1'b0, w: 1'b0, a: 14'h0, be: 4'h0, d: 32'h0};
  endfunction
  function automatic req_t f_rd(input logic [13:0] a);
    return '{r: 1'b1, w: 1'b0, a: a, be: 4'h0, d: 32'h0};
  endfunction
  function automatic req_t f_wr(input logic [13:0] a, input logic [31:0] d,
                                input logic [3:0] be);
    return '{r: 1'b0, w: 1'b1, a: a, be: be, d: d};
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic model_reset();
    last_gnt  = 1;
    pend_port = -1;
    pend_rd   = 32'h0;
  endtask

  // One clock cycle: capture last cycle's strobes, drive, predict.
  task automatic step(input req_t q0, input req_t q1);
    int   win;
    req_t q;
    logic oor;
    @(negedge clk);
    obs_rv0 = m0_if.readdatavalid;
    obs_rv1 = m1_if.readdatavalid;
    obs_rd0 = m0_if.readdata;
    obs_rd1 = m1_if.readdata;
    exp_rv0 = (pend_port == 0);
    exp_rv1 = (pend_port == 1);
    exp_rd  = pend_rd;
    m0_if.read = q0.r; m0_if.write = q0.w; m0_if.address = q0.a;
    m0_if.byteenable = q0.be; m0_if.writedata = q0.d;
    m1_if.read = q1.r; m1_if.write = q1.w; m1_if.address = q1.a;
    m1_if.byteenable = q1.be; m1_if.writedata = q1.d;
    #1;
    obs_w0 = m0_if.waitrequest;
    obs_w1 = m1_if.waitrequest;
    obs_cs = mem_chipselect;
    obs_mw = mem_write;
    obs_be = mem_byteenable;
    if ((q0.r | q0.w) && (q1.r | q1.w)) win = (last_gnt == 0) ? 1 : 0;
    else if (q0.r | q0.w) win = 0;
    else if (q1.r | q1.w) win = 1;
    else win = -1;
    exp_w0 = (q0.r | q0.w) && (win != 0);
    exp_w1 = (q1.r | q1.w) && (win != 1);
    pend_port = -1;
    exp_cs = 1'b0;
    exp_mw = 1'b0;
    if (win >= 0) begin
      q = (win == 1) ? q1 : q0;
      oor = (int'(q.a) >= 16000);
      exp_cs = !oor;
      exp_mw = q.w && !oor;
      if (q.w) begin
        if (!oor) ref_mem[int'(q.a)] = merge(ref_rd(int'(q.a)), q.d, q.be);
      end else begin
        pend_port = win;
        pend_rd = oor ? 32'h0 : ref_rd(int'(q.a));
      end
      last_gnt = win;
    end
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] v);
    step(f_idle(), f_idle());
    pl_a = a; pl_d = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[int'(a)] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    m0_if.read = 0; m0_if.write = 0; m1_if.read = 0; m1_if.write = 0;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    m0_if.read = 0; m0_if.write = 0; m1_if.read = 0; m1_if.write = 0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rv0 got %b exp 0", m0_if.readdatavalid); end
    checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rv1 got %b exp 0", m1_if.readdatavalid); end
    checks++; if ({m0_if.waitrequest, m1_if.waitrequest} !== 2'b00) begin errors++; $display("FAIL rst_wait got %b exp 00", {m0_if.waitrequest, m1_if.waitrequest}); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", mem_chipselect); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_read();
    preload(14'h0010, 32'hCAFEF00D);
    step(f_rd(14'h0010), f_idle());
    checks++; if (obs_w0 !== 1'b0) begin errors++; $display("FAIL t1_wait0 got %b exp 0", obs_w0); end
    checks++; if (obs_be !== 4'hF) begin errors++; $display("FAIL t1_be got %h exp f", obs_be); end
    step(f_idle(), f_idle());
    checks++; if (obs_rv0 !== 1'b1) begin errors++; $display("FAIL t1_rv0 got %b exp 1", obs_rv0); end
    checks++; if (obs_rd0 !== 32'hCAFEF00D) begin errors++; $display("FAIL t1_rd got %h exp cafef00d", obs_rd0); end
    checks++; if (obs_rv1 !== 1'b0) begin errors++; $display("FAIL t1_rv1 got %b exp 0", obs_rv1); end
  endtask

  task automatic test_alternate();
    preload(14'h0200, 32'h00000A00);
    preload(14'h0201, 32'h00000B01);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(f_rd(14'h0200), f_rd(14'h0201));
      checks++; if (obs_w0 !== 1'(i % 2 == 1)) begin errors++; $display("FAIL t2_wait0[%0d] got %b exp %b", i, obs_w0, i % 2 == 1); end
      checks++; if (obs_w1 !== 1'(i % 2 == 0)) begin errors++; $display("FAIL t2_wait1[%0d] got %b exp %b", i, obs_w1, i % 2 == 0); end
      if (i > 0) begin
        checks++; if ({obs_rv0, obs_rv1} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL t2_rv[%0d] got %b%b", i, obs_rv0, obs_rv1); end
        checks++; if (obs_rd0 !== ((i % 2 == 1) ? 32'h00000A00 : 32'h00000B01)) begin errors++; $display("FAIL t2_rd[%0d] got %h", i, obs_rd0); end
      end
    end
    step(f_idle(), f_idle());
    checks++; if ({obs_rv0, obs_rv1} !== 2'b01) begin errors++; $display("FAIL t2_last_rv got %b%b exp 01", obs_rv0, obs_rv1); end
  endtask

  task automatic test_byte_write();
    preload(14'h0100, 32'hFFFFFFFF);
    step(f_idle(), f_wr(14'h0100, 32'h11223344, 4'b0101));
    checks++; if (obs_w1 !== 1'b0) begin errors++; $display("FAIL t3_wait1 got %b exp 0", obs_w1); end
    checks++; if (obs_mw !== 1'b1) begin errors++; $display("FAIL t3_mw got %b exp 1", obs_mw); end
    checks++; if (obs_be !== 4'b0101) begin errors++; $display("FAIL t3_be got %b exp 0101", obs_be); end
    step(f_rd(14'h0100), f_idle());
    checks++; if ({obs_rv0, obs_rv1} !== 2'b00) begin errors++; $display("FAIL t3_wr_strobe got %b%b exp 00", obs_rv0, obs_rv1); end
    step(f_idle(), f_idle());
    checks++; if (obs_rv0 !== 1'b1) begin errors++; $display("FAIL t3_rv0 got %b exp 1", obs_rv0); end
    checks++; if (obs_rd0 !== 32'hFF22FF44) begin errors++; $display("FAIL t3_rd got %h exp ff22ff44", obs_rd0); end
  endtask

  task automatic test_oor();
    step(f_wr(14'd16000, 32'h12345678, 4'hF), f_idle());
    checks++; if ({obs_cs, obs_mw} !== 2'b00) begin errors++; $display("FAIL t4_wr_cs got %b%b exp 00", obs_cs, obs_mw); end
    checks++; if (obs_w0 !== 1'b0) begin errors++; $display("FAIL t4_wr_wait got %b exp 0", obs_w0); end
    step(f_rd(14'd16000), f_idle());
    checks++; if (obs_cs !== 1'b0) begin errors++; $display("FAIL t4_rd0_cs got %b exp 0", obs_cs); end
    step(f_rd(14'd16383), f_idle());
    checks++; if (obs_cs !== 1'b0) begin errors++; $display("FAIL t4_rd1_cs got %b exp 0", obs_cs); end
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'h0}) begin errors++; $display("FAIL t4_rd16000 got %b/%h exp 1/0", obs_rv0, obs_rd0); end
    step(f_wr(14'd15999, 32'h5EEDBEEF, 4'hF), f_idle());
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'h0}) begin errors++; $display("FAIL t4_rd16383 got %b/%h exp 1/0", obs_rv0, obs_rd0); end
    checks++; if ({obs_cs, obs_mw} !== 2'b11) begin errors++; $display("FAIL t4_wr15999 got %b%b exp 11", obs_cs, obs_mw); end
    step(f_rd(14'd15999), f_idle());
    checks++; if (obs_cs !== 1'b1) begin errors++; $display("FAIL t4_rd15999_cs got %b exp 1", obs_cs); end
    step(f_idle(), f_idle());
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'h5EEDBEEF}) begin errors++; $display("FAIL t4_rd15999 got %b/%h exp 1/5eedbeef", obs_rv0, obs_rd0); end
  endtask

  task automatic test_reset_mid_read();
    step(f_rd(14'h0010), f_idle());
    step(f_idle(), f_idle());
    checks++; if (obs_rv0 !== 1'b1) begin errors++; $display("FAIL t5_pre_rv0 got %b exp 1", obs_rv0); end
    reset_n = 1'b0;
    #1;
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL t5_async_kill got %b exp 0", m0_if.readdatavalid); end
    reset_n = 1'b1;
    model_reset();
    step(f_rd(14'h0010), f_idle());
    checks++; if (obs_w0 !== 1'b0) begin errors++; $display("FAIL t5_gnt got %b exp 0", obs_w0); end
    m0_if.read = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL t5_killed_rv0 got %b exp 0", m0_if.readdatavalid); end
    reset_n = 1'b1;
    model_reset();
    step(f_rd(14'h0010), f_rd(14'h0100));
    checks++; if ({obs_w0, obs_w1} !== 2'b01) begin errors++; $display("FAIL t5_first_gnt got %b%b exp 01", obs_w0, obs_w1); end
    step(f_idle(), f_rd(14'h0100));
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL t5_rv0 got %b/%h", obs_rv0, obs_rd0); end
    step(f_idle(), f_idle());
    checks++; if ({obs_rv1, obs_rd1} !== {1'b1, 32'hFF22FF44}) begin errors++; $display("FAIL t5_rv1 got %b/%h", obs_rv1, obs_rd1); end
  endtask

  task automatic test_rw_both();
    req_t q;
    q = f_wr(14'h0020, 32'hA5A5A5A5, 4'hF);
    q.r = 1'b1;
    step(q, f_idle());
    checks++; if (obs_mw !== 1'b1) begin errors++; $display("FAIL t6_mw got %b exp 1", obs_mw); end
    step(f_rd(14'h0020), f_idle());
    checks++; if (obs_rv0 !== 1'b0) begin errors++; $display("FAIL t6_no_strobe got %b exp 0", obs_rv0); end
    step(f_idle(), f_idle());
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'hA5A5A5A5}) begin errors++; $display("FAIL t6_rd got %b/%h exp 1/a5a5a5a5", obs_rv0, obs_rd0); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] a0, a1;
    for (int i = 0; i < 4; i++) begin
      preload(14'h0600 + 14'(i), 32'h60000000 + i);
      preload(14'h0610 + 14'(i), 32'h61000000 + i);
    end
    preload(14'h0620, 32'h0BADF00D);
    a0 = 14'h0600; a1 = 14'h0610;
    for (int i = 0; i < 8; i++) begin
      step(f_rd(a0), f_rd(a1));
      if (!exp_w0) a0 = 14'h0600 + ((a0 + 14'd1) & 14'd3);
      if (!exp_w1) a1 = 14'h0610 + ((a1 + 14'd1) & 14'd3);
      if (i > 0) begin
        checks++; if ({obs_rv0, obs_rv1} !== {exp_rv0, exp_rv1} || !(exp_rv0 ^ exp_rv1)) begin errors++; $display("FAIL b2b_rv[%0d] got %b%b exp %b%b", i, obs_rv0, obs_rv1, exp_rv0, exp_rv1); end
        checks++; if (obs_rd0 !== exp_rd) begin errors++; $display("FAIL b2b_rd[%0d] got %h exp %h", i, obs_rd0, exp_rd); end
      end
    end
    step(f_idle(), f_idle());
    step(f_rd(14'h0620), f_idle());
    step(f_idle(), f_wr(14'h0620, 32'hDEAD0001, 4'hF));
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL rw_interleave got %b/%h exp 1/0badf00d", obs_rv0, obs_rd0); end
    step(f_rd(14'h0620), f_idle());
    step(f_idle(), f_idle());
    checks++; if ({obs_rv0, obs_rd0} !== {1'b1, 32'hDEAD0001}) begin errors++; $display("FAIL rw_after got %b/%h exp 1/dead0001", obs_rv0, obs_rd0); end
  endtask

  function automatic req_t rand_req();
    req_t q;
    int   k;
    k = $urandom_range(0, 9);
    q.a  = 14'h0500 + 14'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) q.a = 14'(16000 + $urandom_range(0, 383));
    q.be = 4'($urandom);
    q.d  = $urandom;
    q.r  = (k >= 3 && k <= 5) || k == 9;
    q.w  = (k >= 6);
    return q;
  endfunction

  task automatic test_random();
    req_t c0, c1;
    logic h0, h1;
    for (int i = 0; i < 16; i++) preload(14'h0500 + 14'(i), $urandom);
    h0 = 1'b0; h1 = 1'b0;
    c0 = f_idle(); c1 = f_idle();
    for (int i = 0; i < 300; i++) begin
      if (!h0) c0 = rand_req();
      if (!h1) c1 = rand_req();
      step(c0, c1);
      checks++; if ({obs_w0, obs_w1} !== {exp_w0, exp_w1}) begin errors++; $display("FAIL rnd_wait[%0d] got %b%b exp %b%b", i, obs_w0, obs_w1, exp_w0, exp_w1); end
      checks++; if ({obs_cs, obs_mw} !== {exp_cs, exp_mw}) begin errors++; $display("FAIL rnd_mem[%0d] got %b%b exp %b%b", i, obs_cs, obs_mw, exp_cs, exp_mw); end
      checks++; if ({obs_rv0, obs_rv1} !== {exp_rv0, exp_rv1}) begin errors++; $display("FAIL rnd_rv[%0d] got %b%b exp %b%b", i, obs_rv0, obs_rv1, exp_rv0, exp_rv1); end
      if (exp_rv0 || exp_rv1) begin
        checks++; if ((exp_rv0 ? obs_rd0 : obs_rd1) !== exp_rd) begin errors++; $display("FAIL rnd_rd[%0d] got %h exp %h", i, exp_rv0 ? obs_rd0 : obs_rd1, exp_rd); end
      end
      h0 = exp_w0;
      h1 = exp_w1;
    end
    step(f_idle(), f_idle());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    m0_if.read = 0; m0_if.write = 0; m0_if.address = '0;
    m0_if.byteenable = '0; m0_if.writedata = '0;
    m1_if.read = 0; m1_if.write = 0; m1_if.address = '0;
    m1_if.byteenable = '0; m1_if.writedata = '0;
    model_reset();
    #1;
    test_reset();
    test_single_read();
    test_alternate();
    test_byte_write();
    test_oor();
    test_reset_mid_read();
    test_rw_both();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
